uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL use parameter OVERSAMPLE, default 16, baud_tick pulses per bit period (even, >= 4).
REQ-002 The block SHALL use parameter DATA_BITS, default 8, data bits per frame.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port baud_tick, input, 1, one-clock enable pulse at OVERSAMPLE x baud rate.
REQ-006 The block SHALL have port rx_in, input, 1, asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_data, output, DATA_BITS, last good received byte.
REQ-008 The block SHALL have port rx_valid, output, 1, one-clock pulse when rx_data updates.
REQ-009 The block SHALL have port frame_err, output, 1, one-clock pulse on a bad stop bit.
REQ-010 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-011 The block SHALL pass rx_in through a two-flop synchronizer (both flops reset to 1), giving rx_s; all decisions use rx_s only.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, BREAK, and SHALL advance and count only in clocks where baud_tick=1, except BREAK exit.
REQ-013 In IDLE, on a baud_tick with rx_s=0, the FSM SHALL enter START and clear the tick counter.
REQ-014 In START, on tick OVERSAMPLE/2 (mid start bit), rx_s=0 SHALL enter DATA with the counter cleared; rx_s=1 (glitch) SHALL return to IDLE with no output pulse.
REQ-015 In DATA, every OVERSAMPLE ticks (mid-bit), the block SHALL shift rx_s into the LSB of the shift register (shift left), MSB first on the wire, matching the team's transmitter order.
REQ-016 After DATA_BITS samples, the FSM SHALL enter STOP; a 3-bit-wide or wider bit counter SHALL cover DATA_BITS without wrap.
REQ-017 In STOP, OVERSAMPLE ticks later: rx_s=1 SHALL load rx_data from the shift register, pulse rx_valid, and go to IDLE; rx_s=0 SHALL pulse frame_err, leave rx_data unchanged, and go to BREAK.
REQ-018 rx_valid and frame_err SHALL assert in the clock after the stop-sample tick, last exactly one clock, and never assert together.
REQ-019 BREAK SHALL return to IDLE on the first clock with rx_s=1, regardless of baud_tick, so a held-low line yields exactly one frame_err.
REQ-020 rx_data SHALL hold its value between rx_valid pulses.
REQ-021 If baud_tick stays low, the FSM, counters, and outputs SHALL freeze (pulses still drop after one clock).
REQ-022 The block SHALL have no receive buffering: a new byte overwrites rx_data, and the consumer must take it on rx_valid.

Reset
REQ-023 When reset_n=0, asynchronously: state=IDLE, counters=0, shift register=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no rx_valid or frame_err; after release, reception restarts at the next start bit.

Structure
REQ-025 A shared package uart_pkg SHALL hold the FSM state encoding, OVERSAMPLE and DATA_BITS defaults, and the idle-level constant, for use by both TX and RX.
REQ-026 The deserializer SHALL be a sub-module named sipo (clock, reset_n, shift enable, serial in, parallel out), the counterpart of the transmitter's serializer.

Verification
REQ-027 Frame 0xA5, 16 ticks/bit, valid stop -> one rx_valid pulse, rx_data=0xA5, frame_err stays 0.
REQ-028 rx_in low for 4 ticks, then high -> FSM returns to IDLE from START; no rx_valid, no frame_err, rx_data unchanged.
REQ-029 Frame 0x3C with stop bit 0, then line held low for 3 bit times -> exactly one frame_err, no rx_valid, busy high until line rises, then IDLE.
REQ-030 Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses with rx_data 0x00 then 0xFF.
REQ-031 reset_n pulsed low during data bit 4 of 0x5A -> all outputs 0 immediately, no pulse; next frame 0x81 is received correctly.
REQ-032 baud_tick gated off for 50 clocks mid-DATA during 0xC3 -> frame still decodes to 0xC3.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// Holds the receiver FSM state encoding, the default frame geometry and the
// level of an idle serial line.
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    // Default baud_tick pulses per bit period (must be even and >= 4).
    localparam int OVERSAMPLE_DEF = 16;

    // Default number of data bits per frame.
    localparam int DATA_BITS_DEF = 8;

    // Level of the serial line when nothing is being sent.
    localparam logic IDLE_LEVEL = 1'b1;

endpackage : uart_pkg

// File: rtl/sipo.sv
// Serial-in / parallel-out shift register, the receive-side counterpart of
// the transmitter's serializer.
// Ports:
//   clock        - rising-edge clock
//   reset_n      - asynchronous active-low reset, clears the register
//   shift_en     - shift one bit in on this clock
//   serial_in    - bit shifted into the LSB
//   parallel_out - current register contents (older bits toward the MSB)
module sipo #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    // Shift left: the new bit enters at the LSB, so the first bit received
    // ends up in the MSB after WIDTH shifts.
    assign shift_d[0] = serial_in;
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
        assign shift_d[gi] = shift_q[gi-1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
        end else if (shift_en) begin
            shift_q <= shift_d;
        end
    end

    assign parallel_out = shift_q;

endmodule : sipo

// File: rtl/uart_rx.sv
// UART receiver with an oversampled bit clock.
// Detects a start bit, samples each data bit at mid-bit (MSB first on the
// wire), checks the stop bit and reports either a good byte or a framing
// error. A line held low after a bad stop bit is treated as a break and
// produces a single frame_err.
// Ports:
//   clock     - rising-edge clock
//   reset_n   - asynchronous active-low reset
//   baud_tick - one-clock enable at OVERSAMPLE x baud rate
//   rx_in     - asynchronous serial input, idle high
//   rx_data   - last good received word, held between rx_valid pulses
//   rx_valid  - one-clock pulse when rx_data updates
//   frame_err - one-clock pulse on a bad stop bit
//   busy      - high whenever the receiver is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    // At least 3 bits wide, and always wide enough to hold DATA_BITS.
    localparam int BIT_W  = ($clog2(DATA_BITS + 1) > 3) ? $clog2(DATA_BITS + 1) : 3;

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    // Two-flop synchronizer; both flops come out of reset at the idle level
    // so a reset never looks like a start bit.
    logic sync1_q;
    logic rx_s_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= IDLE_LEVEL;
            rx_s_q  <= IDLE_LEVEL;
        end else begin
            sync1_q <= rx_in;
            rx_s_q  <= sync1_q;
        end
    end

    uart_state_e          state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 shift_en;
    logic [DATA_BITS-1:0] shift_word;

    sipo #(
        .WIDTH (DATA_BITS)
    ) u_sipo (
        .clock        (clock),
        .reset_n      (reset_n),
        .shift_en     (shift_en),
        .serial_in    (rx_s_q),
        .parallel_out (shift_word)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        shift_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (baud_tick && !rx_s_q) begin
                    state_d = ST_START;
                    tick_d  = '0;
                end
            end

            ST_START: begin
                if (baud_tick) begin
                    if (tick_q == HALF_LAST) begin
                        // Mid start bit: a high line here was only a glitch.
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

            ST_DATA: begin
                if (baud_tick) begin
                    if (tick_q == FULL_LAST) begin
                        // Counting started at mid start bit, so this is mid data bit.
                        shift_en = 1'b1;
                        tick_d   = '0;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = ST_STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

            ST_STOP: begin
                if (baud_tick) begin
                    if (tick_q == FULL_LAST) begin
                        tick_d = '0;
                        if (rx_s_q) begin
                            rx_data_d  = shift_word;
                            rx_valid_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

            ST_BREAK: begin
                // Leave as soon as the line rises, without waiting for a tick,
                // so a long break reports only one error.
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int TICK_DIV = 4;

    logic          clock;
    logic          reset_n;
    logic          baud_tick;
    logic          rx_in;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    uart_rx #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .baud_tick (baud_tick),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Tick generator: one pulse every TICK_DIV clocks while enabled.
    logic tick_en = 1'b1;
    initial begin
        int div;
        div = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clock);
            baud_tick = (tick_en && div == TICK_DIV - 1);
            div = (div + 1) % TICK_DIV;
        end
    end

    // Monitor: records every rx_valid word and counts frame errors and
    // protocol violations (wide pulses, overlap, rx_data drift).
    logic [DB-1:0] got_q[$];
    int            ferr_seen = 0;
    int            both_err  = 0;
    int            wide_err  = 0;
    int            hold_err  = 0;
    logic [DB-1:0] mon_held  = '0;
    initial begin
        logic pv, pf;
        pv = 1'b0;
        pf = 1'b0;
        forever begin
            @(negedge clock);
            if (rx_valid && frame_err) both_err++;
            if ((rx_valid && pv) || (frame_err && pf)) wide_err++;
            if (rx_valid) begin
                got_q.push_back(rx_data);
                mon_held = rx_data;
            end else if (rx_data !== mon_held) begin
                hold_err++;
                mon_held = rx_data;
            end
            if (frame_err) ferr_seen++;
            pv = rx_valid;
            pf = frame_err;
        end
    end

    // Watchdog: a stuck bench stops with a FAIL line.
    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Reference model state.
    logic [DB-1:0] exp_data = '0;

    task automatic wait_ticks(input int n);
        int c;
        c = 0;
        while (c < n) begin
            @(posedge clock);
            if (baud_tick) c++;
        end
        @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        wait_ticks(OS);
    endtask

    // Start bit, data MSB first, then the given stop level (left on the line).
    task automatic send_frame(input logic [DB-1:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = DB - 1; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        rx_in   = 1'b1;
        repeat (5) @(negedge clock);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy_low: got %b want 0", busy); else n_pass++;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        $display("reset: rx_data=%h busy=%b", rx_data, busy);
    endtask

    task automatic test_basic_a5;
        int f0;
        f0 = ferr_seen;
        send_frame(8'hA5, 1'b1);
        wait_ticks(4);
        exp_data = 8'hA5;
        n_checks++; if (got_q.size() != 1) $display("FAIL a5_pulses: got %0d want 1", got_q.size()); else n_pass++;
        if (got_q.size() > 0) begin
            n_checks++; if (got_q[0] !== exp_data) $display("FAIL a5_data: got %h want %h", got_q[0], exp_data); else n_pass++;
        end
        n_checks++; if (ferr_seen != f0) $display("FAIL a5_ferr: got %0d want 0", ferr_seen - f0); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL a5_idle: got busy=%b want 0", busy); else n_pass++;
        $display("frame A5: pulses=%0d rx_data=%h", got_q.size(), rx_data);
        got_q.delete();
    endtask

    task automatic test_glitch;
        int f0;
        f0 = ferr_seen;
        rx_in = 1'b0;
        wait_ticks(4);
        n_checks++; if (busy !== 1'b1) $display("FAIL glitch_busy_start: got %b want 1", busy); else n_pass++;
        rx_in = 1'b1;
        wait_ticks(2 * OS);
        n_checks++; if (busy !== 1'b0) $display("FAIL glitch_idle: got busy=%b want 0", busy); else n_pass++;
        n_checks++; if (got_q.size() != 0) $display("FAIL glitch_valid: got %0d pulses want 0", got_q.size()); else n_pass++;
        n_checks++; if (ferr_seen != f0) $display("FAIL glitch_ferr: got %0d want 0", ferr_seen - f0); else n_pass++;
        n_checks++; if (rx_data !== exp_data) $display("FAIL glitch_data: got %h want %h", rx_data, exp_data); else n_pass++;
        $display("glitch: busy=%b rx_data=%h", busy, rx_data);
        got_q.delete();
    endtask

    task automatic test_frame_error;
        int f0;
        f0 = ferr_seen;
        send_frame(8'h3C, 1'b0);
        wait_ticks(3 * OS);
        n_checks++; if (ferr_seen - f0 != 1) $display("FAIL ferr_count: got %0d want 1", ferr_seen - f0); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL ferr_busy_break: got %b want 1", busy); else n_pass++;
        n_checks++; if (got_q.size() != 0) $display("FAIL ferr_valid: got %0d pulses want 0", got_q.size()); else n_pass++;
        rx_in = 1'b1;
        repeat (4) @(negedge clock);
        n_checks++; if (busy !== 1'b0) $display("FAIL ferr_exit: got busy=%b want 0", busy); else n_pass++;
        n_checks++; if (rx_data !== exp_data) $display("FAIL ferr_data: got %h want %h", rx_data, exp_data); else n_pass++;
        $display("frame 3C bad stop: frame_err pulses=%0d rx_data=%h", ferr_seen - f0, rx_data);
        wait_ticks(OS);
        got_q.delete();
    endtask

    task automatic test_back_to_back;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_ticks(4);
        n_checks++; if (got_q.size() != 2) $display("FAIL b2b_pulses: got %0d want 2", got_q.size()); else n_pass++;
        if (got_q.size() == 2) begin
            n_checks++; if (got_q[0] !== 8'h00) $display("FAIL b2b_first: got %h want 00", got_q[0]); else n_pass++;
            n_checks++; if (got_q[1] !== 8'hFF) $display("FAIL b2b_second: got %h want ff", got_q[1]); else n_pass++;
        end
        exp_data = 8'hFF;
        $display("back-to-back: pulses=%0d rx_data=%h", got_q.size(), rx_data);
        got_q.delete();
    endtask

    task automatic test_reset_mid;
        logic [DB-1:0] d;
        int            f0;
        d  = 8'h5A;
        f0 = ferr_seen;
        send_bit(1'b0);
        for (int i = DB - 1; i > 4; i--) send_bit(d[i]);
        rx_in = d[4];
        wait_ticks(OS / 2);
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL rstmid_data: got %h want 00", rx_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) $display("FAIL rstmid_pulses: got valid=%b ferr=%b want 0 0", rx_valid, frame_err); else n_pass++;
        mon_held = '0;
        exp_data = '0;
        rx_in    = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        wait_ticks(2 * OS);
        n_checks++; if (got_q.size() != 0 || ferr_seen != f0) $display("FAIL rstmid_abandon: got valid=%0d ferr=%0d want 0 0", got_q.size(), ferr_seen - f0); else n_pass++;
        send_frame(8'h81, 1'b1);
        wait_ticks(4);
        exp_data = 8'h81;
        n_checks++; if (got_q.size() != 1) $display("FAIL rstmid_next_pulses: got %0d want 1", got_q.size()); else n_pass++;
        n_checks++; if (rx_data !== exp_data) $display("FAIL rstmid_next_data: got %h want %h", rx_data, exp_data); else n_pass++;
        $display("reset mid-frame then 81: rx_data=%h", rx_data);
        got_q.delete();
    endtask

    task automatic test_tick_gate;
        logic [DB-1:0] d;
        d = 8'hC3;
        send_bit(1'b0);
        for (int i = DB - 1; i > 4; i--) send_bit(d[i]);
        rx_in = d[4];
        wait_ticks(5);
        tick_en = 1'b0;
        repeat (50) @(negedge clock);
        n_checks++; if (busy !== 1'b1) $display("FAIL gate_frozen_busy: got %b want 1", busy); else n_pass++;
        tick_en = 1'b1;
        wait_ticks(OS - 5);
        for (int i = 3; i >= 0; i--) send_bit(d[i]);
        send_bit(1'b1);
        wait_ticks(4);
        exp_data = d;
        n_checks++; if (got_q.size() != 1) $display("FAIL gate_pulses: got %0d want 1", got_q.size()); else n_pass++;
        n_checks++; if (rx_data !== exp_data) $display("FAIL gate_data: got %h want %h", rx_data, exp_data); else n_pass++;
        $display("tick gated frame C3: rx_data=%h", rx_data);
        got_q.delete();
    endtask

    task automatic test_random;
        for (int n = 0; n < 8; n++) begin
            logic [DB-1:0] d;
            logic          stop;
            int            f0, exp_pulses, exp_ferr;
            d    = DB'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            f0   = ferr_seen;
            wait_ticks($urandom_range(0, 20));
            send_frame(d, stop);
            if (stop) begin
                exp_data   = d;
                exp_pulses = 1;
                exp_ferr   = 0;
            end else begin
                wait_ticks($urandom_range(0, 2 * OS));
                rx_in      = 1'b1;
                exp_pulses = 0;
                exp_ferr   = 1;
            end
            wait_ticks(2);
            n_checks++; if (got_q.size() != exp_pulses) $display("FAIL rand_pulses[%0d]: got %0d want %0d", n, got_q.size(), exp_pulses); else n_pass++;
            n_checks++; if (ferr_seen - f0 != exp_ferr) $display("FAIL rand_ferr[%0d]: got %0d want %0d", n, ferr_seen - f0, exp_ferr); else n_pass++;
            n_checks++; if (rx_data !== exp_data) $display("FAIL rand_data[%0d]: got %h want %h", n, rx_data, exp_data); else n_pass++;
            $display("random frame %0d: sent=%h stop=%b rx_data=%h", n, d, stop, rx_data);
            got_q.delete();
        end
    endtask

    task automatic test_protocol;
        n_checks++; if (both_err != 0) $display("FAIL proto_overlap: got %0d want 0", both_err); else n_pass++;
        n_checks++; if (wide_err != 0) $display("FAIL proto_width: got %0d want 0", wide_err); else n_pass++;
        n_checks++; if (hold_err != 0) $display("FAIL proto_hold: got %0d want 0", hold_err); else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0;
        rx_in   = 1'b1;
        test_reset();
        test_basic_a5();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid();
        test_tick_gate();
        test_random();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_rx
